// File: rtl/dispatch_4way16_pkg.sv
// Shared constants and types for the 4-way 16-bit dispatcher.
package dispatch_4way16_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NUM_LANE = 4;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;

  // Occupancy is encoded directly in the state value so it can be compared
  // against FIFO_DEPTH without a separate counter.
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } lane_state_e;

  // One-hot lane decode of a 2-bit select.
  function automatic logic [NUM_LANE-1:0] lane_onehot(input logic [1:0] sel);
    logic [NUM_LANE-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dispatch_4way16_fifo2_16.sv
// Two-entry lane FIFO. State | meaning:
//   ST_EMPTY | no words held, head invalid
//   ST_ONE   | head_q valid, tail_q unused
//   ST_FULL  | head_q and tail_q valid, pushes refused
module fifo2_16
  import dispatch_4way16_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [1:0]   occ_o,
  output logic [W-1:0] head_o,
  output logic         valid_o
);

  lane_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push_ok;
  logic         pop_ok;

  // Guard the handshakes locally so a misbehaving parent cannot overrun or
  // underrun the two entries; flush overrides both.
  assign push_ok = push_i & (state_q != ST_FULL)  & ~flush_i;
  assign pop_ok  = pop_i  & (state_q != ST_EMPTY) & ~flush_i;

  // State and storage registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next-state and data movement; push+pop at ONE replaces the head in place.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push_ok) begin
            head_d  = din_i;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push_ok && pop_ok) begin
            head_d = din_i;
          end else if (push_ok) begin
            tail_d  = din_i;
            state_d = ST_FULL;
          end else if (pop_ok) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop_ok) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign occ_o   = state_q;
  assign head_o  = head_q;
  assign valid_o = (state_q != ST_EMPTY);

endmodule

// File: rtl/dispatch_4way16.sv
// Buffered 4-way dispatcher: sel decode, per-lane 2-entry FIFOs, per-lane
// wrap-around accept counters and zero-forced outputs for empty lanes.
module dispatch_4way16
  import dispatch_4way16_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [WIDTH-1:0]          in_i,
  input  logic [1:0]                sel_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [WIDTH-1:0]          a_o,
  output logic [WIDTH-1:0]          b_o,
  output logic [WIDTH-1:0]          c_o,
  output logic [WIDTH-1:0]          d_o,
  output logic [NUM_LANE-1:0]       out_valid_o,
  input  logic [NUM_LANE-1:0]       out_ready_i,
  output logic [NUM_LANE*CNT_W-1:0] cnt_o
);

  logic [1:0]          lane_occ  [NUM_LANE];
  logic [WIDTH-1:0]    lane_head [NUM_LANE];
  logic [WIDTH-1:0]    lane_out  [NUM_LANE];
  logic [NUM_LANE-1:0] lane_valid;
  logic [NUM_LANE-1:0] push_en;
  logic [NUM_LANE-1:0] pop_en;
  logic                accept;
  logic [CNT_W-1:0]    cnt_q [NUM_LANE];
  logic [CNT_W-1:0]    cnt_d [NUM_LANE];

  assign in_ready_o = ~flush_i & (lane_occ[sel_i] < FIFO_DEPTH);
  assign accept     = in_valid_i & in_ready_o;
  assign push_en    = accept ? lane_onehot(sel_i) : '0;
  assign pop_en     = lane_valid & out_ready_i;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    fifo2_16 #(.W(WIDTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (push_en[g]),
      .pop_i   (pop_en[g]),
      .din_i   (in_i),
      .occ_o   (lane_occ[g]),
      .head_o  (lane_head[g]),
      .valid_o (lane_valid[g])
    );
    // Stale storage is never exposed: empty lanes read as zero.
    assign lane_out[g] = lane_valid[g] ? lane_head[g] : '0;
  end

  // Counter increments; wrap at 8 bits is natural overflow.
  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push_en[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  // Counter registers; flush deliberately leaves them alone.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_LANE; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANE; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign a_o         = lane_out[LANE_A];
  assign b_o         = lane_out[LANE_B];
  assign c_o         = lane_out[LANE_C];
  assign d_o         = lane_out[LANE_D];
  assign out_valid_o = lane_valid;
  assign cnt_o       = {cnt_q[LANE_D], cnt_q[LANE_C], cnt_q[LANE_B], cnt_q[LANE_A]};

endmodule

// File: tb/tb_dispatch_4way16.sv
module tb_dispatch_4way16;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] din;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, c, d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] cnt;

  logic [15:0] lane_out [4];
  assign lane_out[0] = a;
  assign lane_out[1] = b;
  assign lane_out[2] = c;
  assign lane_out[3] = d;

  dispatch_4way16 dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .in_i        (din),
    .sel_i       (sel),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_o         (a),
    .b_o         (b),
    .c_o         (c),
    .d_o         (d),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .cnt_o       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one queue of expected words per lane, plus counter model.
  logic [15:0] sbq [4][$];
  logic [7:0]  mcnt [4];
  int npass  = 0;
  int ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      sbq[i].delete();
      mcnt[i] = 8'h00;
    end
  endtask

  // Check all outputs against the scoreboard, then advance model and DUT one edge.
  task automatic tick();
    logic       exp_rdy;
    logic [3:0] exp_vld;
    #1;
    exp_rdy = !flush && (sbq[sel].size() < 2);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    for (int i = 0; i < 4; i++) begin
      exp_vld[i] = (sbq[i].size() != 0);
      chk($sformatf("lane%0d_data", i), {16'b0, lane_out[i]},
          {16'b0, (sbq[i].size() != 0) ? sbq[i][0] : 16'h0000});
    end
    chk("out_valid", {28'b0, out_valid}, {28'b0, exp_vld});
    chk("cnt", cnt, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
    if (flush) begin
      for (int i = 0; i < 4; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < 4; i++)
        if (out_ready[i] && sbq[i].size() != 0) void'(sbq[i].pop_front());
      if (in_valid && exp_rdy) begin
        sbq[sel].push_back(din);
        mcnt[sel] = mcnt[sel] + 8'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [15:0] w);
    in_valid = 1'b1;
    sel      = s;
    din      = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    din       = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    model_clear();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, idle.
    tick();
    tick();

    // Lane c fill, refused third push, pop order.
    push(2'd2, 16'h1234);
    push(2'd2, 16'h5678);
    push(2'd2, 16'h9ABC);
    out_ready = 4'b0100; tick();
    out_ready = 4'b0000; tick();
    out_ready = 4'b0100; tick();
    out_ready = 4'b0000; tick();

    // Lane d full: push refused while pop taken same cycle.
    push(2'd3, 16'hD001);
    push(2'd3, 16'hD002);
    out_ready = 4'b1000;
    push(2'd3, 16'hD003);
    out_ready = 4'b0000; tick();
    chk("d_after_refused_push", {16'b0, d}, 32'h0000_D002);
    chk("cnt_d_unchanged", {24'b0, cnt[31:24]}, 32'd2);
    out_ready = 4'b1000; tick();
    out_ready = 4'b0000;

    // Push+pop on same lane at occupancy 1, and push lane b while popping a.
    push(2'd0, 16'h0A01);
    out_ready = 4'b0001;
    push(2'd0, 16'h0A02);
    push(2'd1, 16'h0B01);
    out_ready = 4'b0000; tick();

    // Stream 256 words into lane a with consumer always ready.
    out_ready = 4'b0001;
    for (int i = 0; i < 256; i++) push(2'd0, 16'hA000 + 16'(i));
    tick();
    chk("cnt_a_wrapped", {24'b0, cnt[7:0]}, 32'h0000_0002);
    out_ready = 4'b0000; tick();

    // Fill every lane past capacity, then flush.
    out_ready = 4'b0010; tick();
    out_ready = 4'b0000;
    push(2'd0, 16'h1111);
    for (int i = 0; i < 2; i++) push(2'd1, 16'h2220 + 16'(i));
    for (int i = 0; i < 3; i++) push(2'd2, 16'h3330 + 16'(i));
    for (int i = 0; i < 4; i++) push(2'd3, 16'h4440 + 16'(i));
    tick();
    flush = 1'b1; in_valid = 1'b1; sel = 2'd0; din = 16'hFFFF; out_ready = 4'b1111;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    tick();
    chk("flush_out_valid", {28'b0, out_valid}, 32'd0);
    push(2'd1, 16'h5150);

    // Asynchronous reset between edges.
    push(2'd1, 16'h5151);
    in_valid = 1'b1; sel = 2'd1; din = 16'h5152;
    #3;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_out_valid", {28'b0, out_valid}, 32'd0);
    chk("rst_b", {16'b0, b}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    push(2'd0, 16'hBEEF);
    tick();
    chk("post_rst_a", {16'b0, a}, 32'h0000_BEEF);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/dispatch_4way16.md
# dispatch_4way16

Buffered 4-way 16-bit word dispatcher: accepts one 16-bit word plus a 2-bit lane select per handshake and routes it into one of four independent 2-entry lane FIFOs (lanes a, b, c, d). It is the sequential stage that wraps 4-way demultiplexing: it owns the lane-select decode and supplies registered, flow-controlled outputs to four downstream consumers, such as register-file write ports or per-unit command queues. Per-lane wrap-around word counters support bring-up and debug.

## Interface
- WIDTH, 16, data word width
- DEPTH, 2, entries per lane FIFO (fixed at 2; other values unsupported)
- clk  input  1  system clock, rising-edge
- reset  input  1  one clock; reset is asynchronous and active-high
- flush  input  1  synchronous clear of all lane FIFOs (counters kept)
- in  input  16  word to dispatch
- sel  input  2  destination lane: 0=a, 1=b, 2=c, 3=d
- in_valid  input  1  in/sel valid
- in_ready  output  1  dispatcher accepts in/sel this cycle
- a, b, c, d  output  16 each  head word of each lane; 16'h0000 when lane empty
- out_valid  output  4  per-lane head valid, bit0=a … bit3=d
- out_ready  input  4  per-lane consumer ready, same bit order
- cnt  output  32  per-lane accepted-word counters, 8 bits each: [7:0]=a, [15:8]=b, [23:16]=c, [31:24]=d

## Operation
- Push: `in_valid & in_ready` writes `in` into the tail of lane `sel`, and the count of that lane increments.
- `in_ready` is combinational: `~flush & (occupancy[sel] < 2)`. It depends on `sel`, which is legal because `sel` is qualified by `in_valid`.
- Pop: `out_valid[i] & out_ready[i]` removes the head of lane i. All four lanes pop independently in the same cycle.
- Simultaneous push and pop on the same lane:
  - Occupancy 1: the pop consumes the old head, the new word becomes the head, and occupancy stays 1.
  - Occupancy 2: the push is refused because `in_ready`=0. There is no pass-through on full.
- Simultaneous push to lane x and pop on lane y≠x: both take effect.
- Lane occupancy runs 0→1→2. `out_valid[i] = (occupancy[i] != 0)`.
- Ordering is FIFO within a lane. There is no ordering guarantee across lanes.
- Output data for an empty lane is forced to 16'h0000, matching demux semantics for unselected outputs.
- Counters:
  - Each counter increments by 1 on every accepted push to its lane.
  - Each counter is 8-bit and wraps 8'hFF→8'h00.
  - Counters are unaffected by pops and flush.
- Flush:
  - Occupancy of all lanes is set to 0 at the next edge.
  - Pushes are blocked (`in_ready`=0).
  - Pops presented during the flush cycle are ignored.
- Lane FIFO state per lane: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - FULL→ONE on pop.
  - Any state→EMPTY on flush.

## Timing
- Latency: a word accepted at edge N is visible on its lane output with `out_valid` high after edge N. This is 1 cycle.
- Throughput: 1 word/cycle into a lane whose consumer holds `out_ready`=1 continuously. Occupancy stays ≤1.
- Reset (async assert, sync-safe deassert by system):
  - `out_valid`=4'b0000; a, b, c, d = 16'h0000; `cnt`=32'h0.
  - All occupancies are 0, and `in_ready`=1 when `flush`=0.
- Reset mid-operation discards buffered words immediately, with no waiting for an edge.
- All outputs except `in_ready` are registered or derived only from registered state. `in_ready` is combinational from `sel` and `flush`.

## Structure
- Shared package/header holds:
  - lane index constants LANE_A=0, LANE_B=1, LANE_C=2, LANE_D=3;
  - the constant FIFO_DEPTH=2;
  - the constant CNT_W=8.
- One natural sub-module, `fifo2_16`: a 2-entry WIDTH-bit FIFO with push, pop, flush, occupancy, head and valid. It is instantiated four times.
- The top level holds:
  - the sel decode, which generates the per-lane push enables from `sel`;
  - the `in_ready` mux;
  - the four counters;
  - the zero-forcing of empty-lane outputs.

## Test plan
- Reset then idle, `out_ready`=0 → `out_valid`=0, a..d=16'h0000, `cnt`=0, `in_ready`=1.
- Push 16'h1234 to sel=2 with `out_ready`=0 → after 1 edge `out_valid`=4'b0100 and c=16'h1234. Push 16'h5678 to sel=2 → still c=16'h1234. Third push to sel=2 → `in_ready`=0. Pop c → c=16'h5678.
- Lane d full, then push to d with `out_ready[3]`=1 in the same cycle → push refused, pop taken, d occupancy 1, `cnt[31:24]` unchanged.
- Stream 256 words to lane a with `out_ready[0]`=1 continuously → 1 word/cycle accepted, a outputs in order, `cnt[7:0]` wraps back to 8'h00.
- Fill all lanes (a=1, b=2, c=3, d=4 entries capped at 2), then pulse `flush` → `out_valid`=0 next cycle, `in_ready`=0 during flush, counters retain values.
- Assert `reset` asynchronously mid-stream between edges → outputs zero immediately; first push after release lands 1 cycle later.
